// File: rtl/lcd_pix_fifo.sv
// Single-clock pixel FIFO with registered status flags, sticky error flags and
// either a registered-read (standard) or first-word-fall-through output stage.
module lcd_pix_fifo #(
  parameter int DATA_W     = 20,
  parameter int DEPTH_LOG2 = 10,
  parameter int AE_LEVEL   = 32,
  parameter int AF_LEVEL   = 992,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  we,
  input  logic [DATA_W-1:0]     di,
  input  logic                  re,
  output logic [DATA_W-1:0]     dout,   // read data; "do" is a reserved word
  output logic                  empty_flag,
  output logic                  full_flag,
  output logic                  aempty_flag,
  output logic                  afull_flag,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_L  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   AE_L    = (DEPTH_LOG2+1)'(AE_LEVEL);
  localparam logic [DEPTH_LOG2:0]   AF_L    = (DEPTH_LOG2+1)'(AF_LEVEL);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  byp;

  always_comb begin
    wr_acc     = we & ~full_flag;
    rd_acc     = re & ~empty_flag;
    rd_ptr_nxt = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
    level_nxt  = level;
    if (wr_acc && !rd_acc)
      level_nxt = level + LVL_ONE;
    else if (!wr_acc && rd_acc)
      level_nxt = level - LVL_ONE;
    // In FWFT mode the word being written may itself become the new head.
    byp = wr_acc && (wr_ptr == rd_ptr_nxt);
  end

  // Write port of the storage array
  always_ff @(posedge clk) begin
    if (wr_acc && !flush)
      mem[wr_ptr] <= di;
  end

  // Pointers, level, flags and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      empty_flag  <= 1'b1;
      aempty_flag <= 1'b1;
      full_flag   <= 1'b0;
      afull_flag  <= 1'b0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
      dout        <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      empty_flag  <= 1'b1;
      aempty_flag <= 1'b1;
      full_flag   <= 1'b0;
      afull_flag  <= 1'b0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
      dout        <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr      <= rd_ptr_nxt;
      level       <= level_nxt;
      empty_flag  <= (level_nxt == '0);
      full_flag   <= (level_nxt == FULL_L);
      aempty_flag <= (level_nxt <= AE_L);
      afull_flag  <= (level_nxt >= AF_L);
      ovf         <= ovf | (we & full_flag);
      udf         <= udf | (re & empty_flag);
      if (FWFT != 0) begin
        // Track the head word; hold the last value while the FIFO is empty.
        if (level_nxt != '0)
          dout <= byp ? di : mem[rd_ptr_nxt];
      end else if (rd_acc) begin
        dout <= mem[rd_ptr];
      end
    end
  end

endmodule
